motor_phase_monitor: RTL

MOTOR_PHASE_MONITOR -- requirements
Module: motor_phase_monitor

---
 rtl/motor_phase_monitor_pkg.sv | 41 ++++
 rtl/motor_phase_monitor_phase_sync.sv | 39 +++
 rtl/motor_phase_monitor.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/motor_phase_monitor_pkg.sv
// Shared definitions for the stepper coil phase monitor: the four legal
// one-hot coil patterns, the 2-bit phase index type, the lock FSM states
// and small decode helpers used by the top level.
package motor_pkg;

    localparam logic [3:0] PAT_IDLE = 4'b0000;
    localparam logic [3:0] PAT_PH0  = 4'b0001;
    localparam logic [3:0] PAT_PH1  = 4'b0010;
    localparam logic [3:0] PAT_PH2  = 4'b0100;
    localparam logic [3:0] PAT_PH3  = 4'b1000;

    typedef logic [1:0] phase_t;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_e;

    // True only for the four single-coil drive patterns.
    function automatic logic pat_is_phase(input logic [3:0] pat);
        logic ok;
        case (pat)
            PAT_PH0, PAT_PH1, PAT_PH2, PAT_PH3: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Phase index of a legal pattern; callers qualify with pat_is_phase.
    function automatic phase_t pat_to_phase(input logic [3:0] pat);
        phase_t ph;
        case (pat)
            PAT_PH1: ph = 2'd1;
            PAT_PH2: ph = 2'd2;
            PAT_PH3: ph = 2'd3;
            default: ph = 2'd0;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/motor_phase_monitor_phase_sync.sv
// Coil input conditioning: 2-flop synchronizer followed by a filter that
// accepts a pattern once two consecutive synchronized samples agree.
// new_o is a 1-cycle strobe whenever the accepted pattern changes.
module phase_sync (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] coil_i,
    output logic [3:0] pattern_o,
    output logic       new_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;
    logic [3:0] hist_q;
    logic [3:0] acc_q;

    // Synchronizer chain, one-sample history and the accepted pattern.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
            hist_q <= '0;
            acc_q  <= '0;
        end else begin
            meta_q <= coil_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
            if (new_o) begin
                acc_q <= hist_q;
            end
        end
    end

    // The strobe is decoded from registers so the consumer can act on the
    // very next edge; acc_q catches up on that same edge, ending the strobe.
    assign new_o     = (sync_q == hist_q) && (hist_q != acc_q);
    assign pattern_o = hist_q;

endmodule

// File: rtl/motor_phase_monitor.sv
// Stepper motor phase monitor: tracks the observed coil drive sequence,
// counts forward/reverse steps into a signed wrapping position, and flags
// illegal patterns or skipped phases.
// Optional feature macro: STALL_DETECT_EN adds a stall counter and the
// stalled output; without it both are absent.
module motor_phase_monitor #(
    parameter int POS_W        = 16,
    parameter int STALL_CYCLES = 50000
) (
    input  logic                    clkin,
    input  logic                    reset,
    input  logic [3:0]              coil_in,
    input  logic                    clr_pos,
    input  logic                    err_clr,
    output logic signed [POS_W-1:0] position,
    output logic                    dir,
    output logic                    step_pulse,
    output logic                    phase_err
`ifdef STALL_DETECT_EN
    ,
    output logic                    stalled
`endif
);

    import motor_pkg::*;

    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    logic [3:0]       pat;
    logic             pat_new;

    state_e           state_q;
    phase_t           ref_q;
    logic [POS_W-1:0] pos_q;
    logic             dir_q;
    logic             pulse_q;
    logic             err_q;

    logic             pat_ok;
    logic             is_idle;
    logic             locked;
    phase_t           ph;
    logic             bad;
    logic             relock;
    logic             step_fwd;
    logic             step_rev;
    logic             skip;

    phase_sync u_phase_sync (
        .clk_i     (clkin),
        .rst_i     (reset),
        .coil_i    (coil_in),
        .pattern_o (pat),
        .new_o     (pat_new)
    );

    // Classify each newly accepted pattern against the reference phase.
    always_comb begin
        pat_ok   = pat_is_phase(pat);
        ph       = pat_to_phase(pat);
        is_idle  = (pat == PAT_IDLE);
        locked   = (state_q == ST_LOCKED);
        bad      = pat_new && !is_idle && !pat_ok;
        relock   = pat_new && pat_ok && !locked;
        step_fwd = pat_new && pat_ok && locked && (ph == phase_t'(ref_q + 2'd1));
        step_rev = pat_new && pat_ok && locked && (ph == phase_t'(ref_q - 2'd1));
        skip     = pat_new && pat_ok && locked && (ph == phase_t'(ref_q + 2'd2));
    end

    // Lock FSM with its registered position, direction, pulse and error outputs.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q <= ST_UNLOCKED;
            ref_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pulse_q <= step_fwd | step_rev;

            case (state_q)
                ST_UNLOCKED: if (relock) state_q <= ST_LOCKED;
                ST_LOCKED:   if (bad)    state_q <= ST_UNLOCKED;
                default:     state_q <= ST_UNLOCKED;
            endcase

            if (relock || step_fwd || step_rev || skip) begin
                ref_q <= ph;
            end

            if (step_fwd) begin
                dir_q <= 1'b0;
            end else if (step_rev) begin
                dir_q <= 1'b1;
            end

            // Clear has priority over a coincident step; pulse/dir still update.
            if (clr_pos) begin
                pos_q <= '0;
            end else if (step_fwd) begin
                pos_q <= pos_q + POS_ONE;
            end else if (step_rev) begin
                pos_q <= pos_q - POS_ONE;
            end

            // A new error beats a coincident clear request.
            if (bad || skip) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign position   = pos_q;
    assign dir        = dir_q;
    assign step_pulse = pulse_q;
    assign phase_err  = err_q;

`ifdef STALL_DETECT_EN
    localparam int unsigned CNT_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             stalled_q;

    // Idle-time counter while locked; restarts on any step or unlock.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            stalled_q <= 1'b0;
        end else if (!locked || bad || step_fwd || step_rev) begin
            cnt_q     <= '0;
            stalled_q <= 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            stalled_q <= 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign stalled = stalled_q;
`endif

endmodule
